// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register writeback controller.
// The forwarding option (macro RF_WB_FWD_EN) is selected in rf_wb_ctrl.
package rf_wb_pkg;

  localparam int NUM_REGS    = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 2;
  localparam int CNT_MAX_DEF = 3;

  typedef logic [1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t              dest;
    logic [WIDTH_DEF-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular writeback queue of {dest, data} entries. Every slot is exposed in
// age order (index 0 = head) so the controller can search it for forwarding.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = wb_entry_t
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output entry_t           slot [DEPTH],
  output logic [DEPTH-1:0] slot_vld
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  entry_t           mem [DEPTH];
  ptr_t             rd_ptr;
  ptr_t             wr_ptr;
  logic [CNT_W-1:0] count;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) return '0;
    else                        return p + ptr_t'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    ptr_t idx;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      slot[i]     = mem[idx];
      slot_vld[i] = (CNT_W'(i) < count);
      idx         = next_ptr(idx);
    end
  end

  // The writer only pushes into a full queue when it also pops that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: tracks in-flight writes per register, queues results,
// drains them to the register file and answers hazard/forwarding queries.
// Define RF_WB_FWD_EN to forward queued results instead of stalling on them.
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_dest,
  output logic             issue_ready,
  input  logic             res_valid,
  input  logic [1:0]       res_dest,
  input  logic [WIDTH-1:0] res_data,
  output logic             res_ready,
  input  logic             wb_hold,
  output logic             rf_write,
  output logic [1:0]       rf_addr,
  output logic [WIDTH-1:0] rf_data,
  input  logic [1:0]       q_addr1,
  input  logic [1:0]       q_addr2,
  output logic             stall,
  output logic             fwd1_en,
  output logic             fwd2_en,
  output logic [WIDTH-1:0] fwd1_data,
  output logic [WIDTH-1:0] fwd2_data,
  output logic             err
);

  localparam int PW = $clog2(CNT_MAX + 1);
  localparam int QW = $clog2(DEPTH + 1);

  typedef struct packed {
    reg_addr_t        dest;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           slot [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  entry_t           head;
  entry_t           push_entry;
  logic             full;
  logic             empty;
  logic             drain;
  logic             issue_fire;
  logic             res_fire;

  logic [PW-1:0]    pending  [NUM_REGS];
  logic [PW-1:0]    pend_nxt [NUM_REGS];
  logic [QW-1:0]    qcnt     [NUM_REGS];

  rf_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (res_fire),
    .push_entry (push_entry),
    .pop        (drain),
    .full       (full),
    .empty      (empty),
    .slot       (slot),
    .slot_vld   (slot_vld)
  );

  assign head            = slot[0];
  assign push_entry.dest = res_dest;
  assign push_entry.data = res_data;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid, and valid may be raised or dropped freely.
  assign drain       = !empty && !wb_hold;
  assign rf_write    = drain;
  assign rf_addr     = drain ? head.dest : '0;
  assign rf_data     = drain ? head.data : '0;
  assign res_ready   = !full || drain;
  assign res_fire    = res_valid && res_ready;
  assign issue_ready = (pending[issue_dest] != PW'(CNT_MAX)) ||
                       (drain && (head.dest == issue_dest));
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) qcnt[r] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) qcnt[slot[i].dest] = qcnt[slot[i].dest] + QW'(1);
    end
  end

  // A retire never takes a counter below zero, even for an unsolicited result.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc;
      logic dec;
      inc = issue_fire && (issue_dest == reg_addr_t'(r));
      dec = drain && (head.dest == reg_addr_t'(r)) && (pending[r] != '0);
      pend_nxt[r] = pending[r];
      if (inc && !dec)      pend_nxt[r] = pending[r] + PW'(1);
      else if (dec && !inc) pend_nxt[r] = pending[r] - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pending[r] <= pend_nxt[r];
    end
  end

  // A result with no outstanding issue left to satisfy is a protocol error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (res_fire && (int'(pending[res_dest]) <= int'(qcnt[res_dest]))) begin
      err <= 1'b1;
    end
  end

`ifdef RF_WB_FWD_EN
  logic [NUM_REGS-1:0] fwd_ok;
  logic [WIDTH-1:0]    fwd_val [NUM_REGS];

  // Slots are scanned oldest first, so the youngest match wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      fwd_ok[r]  = (qcnt[r] != '0) && (int'(qcnt[r]) == int'(pending[r]));
      fwd_val[r] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) fwd_val[slot[i].dest] = slot[i].data;
    end
  end

  assign fwd1_en   = fwd_ok[q_addr1];
  assign fwd2_en   = fwd_ok[q_addr2];
  assign fwd1_data = fwd_ok[q_addr1] ? fwd_val[q_addr1] : '0;
  assign fwd2_data = fwd_ok[q_addr2] ? fwd_val[q_addr2] : '0;
  assign stall     = ((pending[q_addr1] != '0) && !fwd_ok[q_addr1]) ||
                     ((pending[q_addr2] != '0) && !fwd_ok[q_addr2]);
`else
  assign fwd1_en   = 1'b0;
  assign fwd2_en   = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
  assign stall     = (pending[q_addr1] != '0) || (pending[q_addr2] != '0);
`endif

endmodule
